pipe_stall_ctrl: RTL and testbench
==================================

# pipe_stall_ctrl

Central pipeline sequencer for the 5-stage, 16-register CPU. Combines the load-use indication from the hazard detection unit, taken-branch resolution from EX, multi-cycle multiply/divide occupancy and halt into one set of pipeline-register enables and flushes. It owns the only sequential stall state in the core: a multiply/divide wait counter and a halt-drain counter. It sits between the ID-stage decode/hazard logic and the write-enable/flush pins of PC, IF/ID, ID/EX and EX/MEM.

## Interface
- MD_LAT, 4, number of cycles a MUL/DIV occupies EX; legal range 2..(2**CNT_W - 1)
- DRAIN_CYC, 3, bubble cycles issued after HALT so EX/MEM/WB retire; legal range 1..(2**CNT_W - 1)
- CNT_W, 3, width of the shared down-counter
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- loadUse  in  1  load-use hazard from hazard detection unit (IDEXMemRead and register match)
- mdStart  in  1  instruction in ID is MUL/DIV
- branchTaken  in  1  EX resolved a taken branch/jump this cycle
- haltReq  in  1  instruction in ID is HALT
- PCWrite  out  1  PC load enable
- IFIDWrite  out  1  IF/ID register load enable
- IFIDFlush  out  1  clear IF/ID to NOP at next edge
- IDEXWrite  out  1  ID/EX register load enable
- IDEXFlush  out  1  load NOP into ID/EX at next edge
- EXMEMFlush  out  1  load NOP into EX/MEM at next edge
- mdBusy  out  1  MUL/DIV occupying EX
- halted  out  1  core stopped

## Operation
- States: RUN, MD_WAIT, DRAIN, HALTED. Counter cnt[CNT_W-1:0].
- Outputs are combinational from state and inputs. Defaults: PCWrite=IFIDWrite=IDEXWrite=1, all flushes 0, mdBusy=0, halted=0.
- RUN, first matching input wins:
  - branchTaken: defaults plus IFIDFlush=1, IDEXFlush=1. Stay in RUN. The other inputs describe a wrong-path instruction and are ignored.
  - haltReq: PCWrite=0, IFIDWrite=0. The HALT passes into ID/EX. Go to DRAIN with cnt=DRAIN_CYC.
  - loadUse: PCWrite=0, IFIDWrite=0, IDEXFlush=1. Stay in RUN. This beats mdStart: ID is held, so mdStart is re-presented next cycle.
  - mdStart: defaults, so the op enters EX. Go to MD_WAIT with cnt=MD_LAT-1.
  - none: defaults.
- MD_WAIT: PCWrite=0, IFIDWrite=0, IDEXWrite=0, EXMEMFlush=1, mdBusy=1. cnt decrements each cycle. When cnt==1, go to RUN. All inputs are ignored.
- DRAIN: PCWrite=0, IFIDWrite=0, IDEXFlush=1. cnt decrements each cycle. When cnt==1, go to HALTED. All inputs are ignored.
- HALTED: PCWrite=IFIDWrite=IDEXWrite=0, halted=1. The only exit is rst.
- Counter arithmetic is unsigned CNT_W bits. cnt is never decremented below 1, so no wrap.

## Timing
- Reset: rst high at a rising edge gives state=RUN and cnt=0 at that edge, from any state, including mid-MD_WAIT and mid-DRAIN.
- While rst is high, outputs are forced to PCWrite=IFIDWrite=IDEXWrite=0, all flushes 0, mdBusy=0, halted=0.
- After rst deasserts with inputs idle: PCWrite=IFIDWrite=IDEXWrite=1, all others 0.
- mdStart accepted in cycle T:
  - mdBusy is high in cycles T+1..T+MD_LAT-1, which is MD_LAT-1 stall cycles.
  - Normal flow resumes at T+MD_LAT, when the result leaves EX.
- haltReq accepted in cycle T:
  - IDEXFlush is high in T+1..T+DRAIN_CYC.
  - halted rises at T+DRAIN_CYC+1 and stays high.
- Load-use stall: exactly one cycle per assertion of loadUse. It is not registered; the hazard unit deasserts once the load has left EX.
- Branch flush: zero added latency; flushes take effect at the same edge the PC loads the target.

## Test plan
- Reset then idle: rst=1 for 2 cycles, then 0 with all inputs 0 -> PCWrite=IFIDWrite=IDEXWrite=1, all flushes 0, mdBusy=0, halted=0.
- Load-use: loadUse=1 for one cycle -> PCWrite=0, IFIDWrite=0, IDEXFlush=1 that cycle only. Then loadUse=1 with mdStart=1 -> stall applied and MD_WAIT not entered. Next cycle mdStart=1 alone -> mdBusy high for exactly 3 cycles (MD_LAT=4), with EXMEMFlush=1 and IDEXWrite=0 throughout.
- Priority: branchTaken=1, haltReq=1 and mdStart=1 together -> IFIDFlush=1, IDEXFlush=1, PCWrite=1, state remains RUN (halted never rises, mdBusy stays 0).
- Halt: haltReq=1 at cycle T -> IDEXFlush high at T+1..T+3, halted=1 from T+4. branchTaken pulses after T have no effect. Outputs are held until rst.
- Reset mid-operation: mdStart, then rst=1 on the second MD_WAIT cycle -> mdBusy=0 after that edge. After rst falls, mdStart -> a full 3-cycle MD_WAIT again (counter reloaded, no residue).
- Parameter sweep: MD_LAT=2, DRAIN_CYC=1 -> mdBusy 1 cycle and halted at T+2. MD_LAT=7 with CNT_W=3 -> mdBusy 6 cycles, no counter wrap.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline sequencer: merges load-use, branch flush, MUL/DIV occupancy
// and halt into the enable/flush pins of PC, IF/ID, ID/EX and EX/MEM.
module pipe_stall_ctrl #(
  parameter int MD_LAT    = 4,
  parameter int DRAIN_CYC = 3,
  parameter int CNT_W     = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic loadUse,
  input  logic mdStart,
  input  logic branchTaken,
  input  logic haltReq,
  output logic PCWrite,
  output logic IFIDWrite,
  output logic IFIDFlush,
  output logic IDEXWrite,
  output logic IDEXFlush,
  output logic EXMEMFlush,
  output logic mdBusy,
  output logic halted
);

  typedef enum logic [1:0] {
    RUN,
    MD_WAIT,
    DRAIN,
    HALTED
  } state_t;

  localparam logic [CNT_W-1:0] MD_LOAD    = CNT_W'(MD_LAT - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The counter leaves its wait state on reaching 1 rather than 0, so it never wraps.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      RUN: begin
        if (branchTaken) begin
          state_nxt = RUN;
        end else if (haltReq) begin
          state_nxt = DRAIN;
          cnt_nxt   = DRAIN_LOAD;
        end else if (loadUse) begin
          state_nxt = RUN;
        end else if (mdStart) begin
          state_nxt = MD_WAIT;
          cnt_nxt   = MD_LOAD;
        end
      end
      MD_WAIT: begin
        if (cnt == CNT_ONE) state_nxt = RUN;
        else                cnt_nxt   = cnt - CNT_ONE;
      end
      DRAIN: begin
        if (cnt == CNT_ONE) state_nxt = HALTED;
        else                cnt_nxt   = cnt - CNT_ONE;
      end
      HALTED: state_nxt = HALTED;
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IFIDFlush  = 1'b0;
    IDEXWrite  = 1'b1;
    IDEXFlush  = 1'b0;
    EXMEMFlush = 1'b0;
    mdBusy     = 1'b0;
    halted     = 1'b0;
    if (rst) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IDEXWrite = 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          // A taken branch makes every other ID-stage request wrong-path.
          if (branchTaken) begin
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
          end else if (haltReq) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
          end else if (loadUse) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
          end
        end
        MD_WAIT: begin
          PCWrite    = 1'b0;
          IFIDWrite  = 1'b0;
          IDEXWrite  = 1'b0;
          EXMEMFlush = 1'b1;
          mdBusy     = 1'b1;
        end
        DRAIN: begin
          PCWrite   = 1'b0;
          IFIDWrite = 1'b0;
          IDEXFlush = 1'b1;
        end
        HALTED: begin
          PCWrite   = 1'b0;
          IFIDWrite = 1'b0;
          IDEXWrite = 1'b0;
          halted    = 1'b1;
        end
        default: begin
          PCWrite   = 1'b0;
          IFIDWrite = 1'b0;
          IDEXWrite = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: three parameterisations driven in lockstep and
// compared against a timestamp-based model, a vector table and corner sequences.
module tb_pipe_stall_ctrl;

  localparam logic [7:0] O_RST  = 8'b0000_0000;
  localparam logic [7:0] O_IDLE = 8'b1101_0000;
  localparam logic [7:0] O_LU   = 8'b0001_1000;
  localparam logic [7:0] O_BR   = 8'b1111_1000;
  localparam logic [7:0] O_HREQ = 8'b0001_0000;
  localparam logic [7:0] O_MDW  = 8'b0000_0110;
  localparam logic [7:0] O_DRN  = 8'b0001_1000;
  localparam logic [7:0] O_HLT  = 8'b0000_0001;

  typedef struct {
    logic       r;
    logic       lu;
    logic       md;
    logic       br;
    logic       hr;
    logic [7:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst, loadUse, mdStart, branchTaken, haltReq;
  wire [7:0] out0, out1, out2;

  int total = 0;
  int bad = 0;
  int now = 0;
  int md_lat[3] = '{4, 2, 7};
  int drn[3]    = '{3, 1, 7};
  int md_end[3];
  int halt_at[3];
  logic [7:0] obs[3];

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.MD_LAT(4), .DRAIN_CYC(3), .CNT_W(3)) dut0 (
    .clk(clk), .rst(rst), .loadUse(loadUse), .mdStart(mdStart),
    .branchTaken(branchTaken), .haltReq(haltReq),
    .PCWrite(out0[7]), .IFIDWrite(out0[6]), .IFIDFlush(out0[5]), .IDEXWrite(out0[4]),
    .IDEXFlush(out0[3]), .EXMEMFlush(out0[2]), .mdBusy(out0[1]), .halted(out0[0]));

  pipe_stall_ctrl #(.MD_LAT(2), .DRAIN_CYC(1), .CNT_W(3)) dut1 (
    .clk(clk), .rst(rst), .loadUse(loadUse), .mdStart(mdStart),
    .branchTaken(branchTaken), .haltReq(haltReq),
    .PCWrite(out1[7]), .IFIDWrite(out1[6]), .IFIDFlush(out1[5]), .IDEXWrite(out1[4]),
    .IDEXFlush(out1[3]), .EXMEMFlush(out1[2]), .mdBusy(out1[1]), .halted(out1[0]));

  pipe_stall_ctrl #(.MD_LAT(7), .DRAIN_CYC(7), .CNT_W(3)) dut2 (
    .clk(clk), .rst(rst), .loadUse(loadUse), .mdStart(mdStart),
    .branchTaken(branchTaken), .haltReq(haltReq),
    .PCWrite(out2[7]), .IFIDWrite(out2[6]), .IFIDFlush(out2[5]), .IDEXWrite(out2[4]),
    .IDEXFlush(out2[3]), .EXMEMFlush(out2[2]), .mdBusy(out2[1]), .halted(out2[0]));

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_count(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model tracks absolute cycle numbers when MUL/DIV ends and when halt begins.
  function automatic logic [7:0] model_out(int i, logic r, logic lu, logic md, logic br, logic hr);
    if (r) return O_RST;
    if (halt_at[i] >= 0) return (now >= halt_at[i]) ? O_HLT : O_DRN;
    if (now < md_end[i]) return O_MDW;
    if (br) return O_BR;
    if (hr) return O_HREQ;
    if (lu) return O_LU;
    return O_IDLE;
  endfunction

  function automatic void model_step(int i, logic r, logic lu, logic md, logic br, logic hr);
    if (r) begin
      md_end[i]  = 0;
      halt_at[i] = -1;
    end else if (halt_at[i] < 0 && now >= md_end[i] && !br) begin
      if (hr)            halt_at[i] = now + drn[i] + 1;
      else if (!lu && md) md_end[i] = now + md_lat[i];
    end
  endfunction

  task automatic apply_stimulus(input logic r, input logic lu, input logic md,
                                input logic br, input logic hr);
    rst = r; loadUse = lu; mdStart = md; branchTaken = br; haltReq = hr;
    @(negedge clk);
    obs[0] = out0; obs[1] = out1; obs[2] = out2;
    for (int i = 0; i < 3; i++)
      check_output($sformatf("model_dut%0d_cyc%0d", i, now), obs[i], model_out(i, r, lu, md, br, hr));
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i, r, lu, md, br, hr);
    now++;
    #1;
  endtask

  vec_t vecs[$];
  int busy_cnt[3];
  int halt_ofs[3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      md_end[i]  = 0;
      halt_at[i] = -1;
    end
    rst = 1'b1; loadUse = 1'b0; mdStart = 1'b0; branchTaken = 1'b0; haltReq = 1'b0;

    //               r     lu    md    br    hr    expected (dut0: MD_LAT=4, DRAIN_CYC=3)
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_RST});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_RST});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_LU});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, O_LU});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_IDLE});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_MDW});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_MDW});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_MDW});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, O_BR});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_HREQ});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_DRN});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_DRN});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_DRN});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_HLT});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_HLT});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_HLT});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_RST});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_IDLE});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_MDW});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_RST});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_IDLE});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_MDW});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_MDW});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_MDW});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE});

    @(posedge clk);
    #1;
    for (int k = 0; k < vecs.size(); k++) begin
      apply_stimulus(vecs[k].r, vecs[k].lu, vecs[k].md, vecs[k].br, vecs[k].hr);
      check_output($sformatf("table_row%0d", k), obs[0], vecs[k].exp);
    end

    // MUL/DIV occupancy per parameterisation: MD_LAT-1 busy cycles, no counter wrap.
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) busy_cnt[i] = 0;
    for (int c = 0; c < 10; c++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) if (obs[i][1]) busy_cnt[i]++;
    end
    check_count("md_busy_lat4", busy_cnt[0], 3);
    check_count("md_busy_lat2", busy_cnt[1], 1);
    check_count("md_busy_lat7", busy_cnt[2], 6);

    // Halt timing: halted first seen DRAIN_CYC+1 cycles after the request.
    for (int i = 0; i < 3; i++) halt_ofs[i] = -1;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 1; c <= 12; c++) begin
      apply_stimulus(1'b0, 1'b0, c[0], ~c[0], 1'b0);
      for (int i = 0; i < 3; i++) if (obs[i][0] && halt_ofs[i] < 0) halt_ofs[i] = c;
    end
    check_count("halt_ofs_drain3", halt_ofs[0], 4);
    check_count("halt_ofs_drain1", halt_ofs[1], 2);
    check_count("halt_ofs_drain7", halt_ofs[2], 8);
    check_output("halt_held_dut0", obs[0], O_HLT);

    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 800; c++) begin
      apply_stimulus($urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                     $urandom_range(0, 19) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
